fir_coeff_loader: RTL and testbench

Coefficient-load stage directly upstream of the FIR filter core's `load`/`coeff_in` port. It collects `NUM_TAPS` 16-bit coefficient words from the HPS-facing word stream and packs them into a shadow register. It then presents the full bus to the filter atomically, with a single-cycle `load` pulse. A timeout guards against a stalled HPS transfer, and an optional checksum word can be required before commit.

---
 rtl/fir_coeff_loader_if.sv | 23 ++
 rtl/fir_coeff_loader.sv | 143 ++++++++++++++
 tb/tb_fir_coeff_loader.sv | 223 ++++++++++++++++++++++
 3 files changed

// File: rtl/fir_coeff_loader_if.sv
// Word-stream and coefficient-bus bundle between the HPS-side driver and fir_coeff_loader.
interface fir_coeff_loader_if #(
    parameter int NUM_TAPS = 4
);
    logic                    start;
    logic                    word_valid;
    logic [15:0]             word_data;
    logic [16*NUM_TAPS-1:0]  coeff_out;
    logic                    load;
    logic                    busy;
    logic                    done;
    logic                    error;

    modport master (
        output start, word_valid, word_data,
        input  coeff_out, load, busy, done, error
    );

    modport slave (
        input  start, word_valid, word_data,
        output coeff_out, load, busy, done, error
    );
endinterface

// File: rtl/fir_coeff_loader.sv
// Collects NUM_TAPS coefficient words into a shadow register and commits them atomically with a load pulse.
// Optional trailing checksum word enabled by defining FIR_COEFF_CHECKSUM_EN.
module fir_coeff_loader #(
    parameter int NUM_TAPS       = 4,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic              clk,
    input  logic              rst,
    fir_coeff_loader_if.slave bus
);
    localparam int CW = $clog2(NUM_TAPS + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES);
    localparam int W  = 16 * NUM_TAPS;

`ifdef FIR_COEFF_CHECKSUM_EN
    typedef enum logic [1:0] {IDLE, COLLECT, CHECK} state_t;
`else
    typedef enum logic [1:0] {IDLE, COLLECT} state_t;
`endif

    state_t          state;
    logic [CW-1:0]   count;
    logic [TW-1:0]   timer;
    logic [W-1:0]    shadow;
    logic [W-1:0]    shadow_next;
    logic [W-1:0]    coeff_reg;
    logic            load_reg;
    logic            busy_reg;
    logic            done_reg;
    logic            error_reg;
    logic            timeout_hit;
    logic            last_word;

    assign bus.coeff_out = coeff_reg;
    assign bus.load      = load_reg;
    assign bus.busy      = busy_reg;
    assign bus.done      = done_reg;
    assign bus.error     = error_reg;

    // The timer reaching TIMEOUT_CYCLES-1 is the abort point, so the check looks one step ahead.
    assign timeout_hit = (timer == TW'(TIMEOUT_CYCLES - 2));
    assign last_word   = (count == CW'(NUM_TAPS - 1));

    always_comb begin
        shadow_next = shadow;
        for (int k = 0; k < NUM_TAPS; k++) begin
            if (int'(count) == k) begin
                shadow_next[16*k +: 16] = bus.word_data;
            end
        end
    end

`ifdef FIR_COEFF_CHECKSUM_EN
    logic [15:0] tap_sum;

    always_comb begin
        tap_sum = '0;
        for (int k = 0; k < NUM_TAPS; k++) begin
            tap_sum = tap_sum + shadow[16*k +: 16];
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            count     <= '0;
            timer     <= '0;
            shadow    <= '0;
            coeff_reg <= '0;
            load_reg  <= 1'b0;
            busy_reg  <= 1'b0;
            done_reg  <= 1'b0;
            error_reg <= 1'b0;
        end else begin
            load_reg <= 1'b0;
            if (bus.start) begin
                state     <= COLLECT;
                count     <= '0;
                timer     <= '0;
                done_reg  <= 1'b0;
                error_reg <= 1'b0;
                busy_reg  <= 1'b1;
            end else begin
                case (state)
                    COLLECT: begin
                        if (bus.word_valid) begin
                            shadow <= shadow_next;
                            count  <= count + 1'b1;
                            timer  <= '0;
                            if (last_word) begin
`ifdef FIR_COEFF_CHECKSUM_EN
                                state <= CHECK;
`else
                                coeff_reg <= shadow_next;
                                load_reg  <= 1'b1;
                                done_reg  <= 1'b1;
                                busy_reg  <= 1'b0;
                                count     <= '0;
                                state     <= IDLE;
`endif
                            end
                        end else if (timeout_hit) begin
                            error_reg <= 1'b1;
                            busy_reg  <= 1'b0;
                            count     <= '0;
                            timer     <= '0;
                            state     <= IDLE;
                        end else begin
                            timer <= timer + 1'b1;
                        end
                    end
`ifdef FIR_COEFF_CHECKSUM_EN
                    CHECK: begin
                        if (bus.word_valid) begin
                            if (bus.word_data == tap_sum) begin
                                coeff_reg <= shadow;
                                load_reg  <= 1'b1;
                                done_reg  <= 1'b1;
                            end else begin
                                error_reg <= 1'b1;
                            end
                            busy_reg <= 1'b0;
                            count    <= '0;
                            timer    <= '0;
                            state    <= IDLE;
                        end else if (timeout_hit) begin
                            error_reg <= 1'b1;
                            busy_reg  <= 1'b0;
                            count     <= '0;
                            timer     <= '0;
                            state     <= IDLE;
                        end else begin
                            timer <= timer + 1'b1;
                        end
                    end
`endif
                    default: ;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_fir_coeff_loader.sv
// Randomized and directed bench for fir_coeff_loader against a word-queue reference model.
module tb_fir_coeff_loader;
    localparam int NUM_TAPS = 4;
    localparam int TIMEOUT  = 16;

    logic clk = 1'b0;
    logic rst;

    fir_coeff_loader_if #(.NUM_TAPS(NUM_TAPS)) bus ();

    fir_coeff_loader #(.NUM_TAPS(NUM_TAPS), .TIMEOUT_CYCLES(TIMEOUT)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int num_checks = 0;
    int num_fails  = 0;
    int load_count = 0;

    // Reference model: words gathered so far, idle cycles since last word, and the visible outputs.
    logic [15:0] m_words[$];
    int          m_idle;
    logic        m_collecting;
    logic [63:0] m_coeff;
    logic        m_load, m_busy, m_done, m_error;

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        num_checks++;
        if (observed !== expected) begin
            num_fails++;
            $display("[TB] FAIL %s: got %h, expected %h at %0t", tag, observed, expected, $time);
        end
    endtask

    function automatic logic [15:0] wordSum();
        logic [15:0] s = '0;
        for (int k = 0; k < NUM_TAPS; k++) s = s + m_words[k];
        return s;
    endfunction

    task automatic modelCommit();
        for (int k = 0; k < NUM_TAPS; k++) m_coeff[16*k +: 16] = m_words[k];
        m_load = 1'b1;
        m_done = 1'b1;
        m_collecting = 1'b0;
    endtask

    task automatic modelEdge(input logic r, input logic st, input logic v, input logic [15:0] d);
        if (r) begin
            m_words.delete();
            m_idle = 0; m_collecting = 1'b0; m_coeff = '0;
            m_load = 1'b0; m_done = 1'b0; m_error = 1'b0;
        end else begin
            m_load = 1'b0;
            if (st) begin
                m_collecting = 1'b1; m_words.delete(); m_idle = 0;
                m_done = 1'b0; m_error = 1'b0;
            end else if (m_collecting) begin
                if (v) begin
                    m_words.push_back(d);
                    m_idle = 0;
`ifdef FIR_COEFF_CHECKSUM_EN
                    if (m_words.size() == NUM_TAPS + 1) begin
                        if (d == wordSum()) modelCommit();
                        else begin m_error = 1'b1; m_collecting = 1'b0; end
                    end
`else
                    if (m_words.size() == NUM_TAPS) modelCommit();
`endif
                end else begin
                    m_idle++;
                    if (m_idle == TIMEOUT - 1) begin
                        m_error = 1'b1;
                        m_collecting = 1'b0;
                    end
                end
            end
        end
        m_busy = m_collecting;
    endtask

    task automatic applyStimulus(input logic r, input logic st, input logic v, input logic [15:0] d);
        rst = r; bus.start = st; bus.word_valid = v; bus.word_data = d;
        @(posedge clk);
        modelEdge(r, st, v, d);
        #1;
        if (bus.load) load_count++;
        checkOutput("coeff_out", bus.coeff_out, m_coeff);
        checkOutput("load", 64'(bus.load), 64'(m_load));
        checkOutput("busy", 64'(bus.busy), 64'(m_busy));
        checkOutput("done", 64'(bus.done), 64'(m_done));
        checkOutput("error", 64'(bus.error), 64'(m_error));
    endtask

    task automatic sendWords(input logic [15:0] w0, w1, w2, w3);
        applyStimulus(0, 1, 0, 16'h0);
        applyStimulus(0, 0, 1, w0);
        applyStimulus(0, 0, 1, w1);
        applyStimulus(0, 0, 1, w2);
        applyStimulus(0, 0, 1, w3);
`ifdef FIR_COEFF_CHECKSUM_EN
        applyStimulus(0, 0, 1, 16'(w0 + w1 + w2 + w3));
`endif
    endtask

    initial begin
        logic [63:0] held;
        int          elapsed;
        int          vp;
        int          r;
        logic        rr, st, v;
        logic [15:0] d;

        modelEdge(1, 0, 0, 16'h0);
        applyStimulus(1, 0, 0, 16'h0);
        applyStimulus(1, 0, 0, 16'h0);

        // Back-to-back load of 1..4
        load_count = 0;
        sendWords(16'h0001, 16'h0002, 16'h0003, 16'h0004);
        checkOutput("basic_coeff", bus.coeff_out, 64'h0004_0003_0002_0001);
        checkOutput("basic_done", 64'(bus.done), 64'd1);
        applyStimulus(0, 0, 0, 16'h0);
        checkOutput("basic_load_once", 64'(load_count), 64'd1);

        // Timeout after two words
        load_count = 0;
        applyStimulus(0, 1, 0, 16'h0);
        applyStimulus(0, 0, 1, 16'h1111);
        applyStimulus(0, 0, 1, 16'h2222);
        elapsed = 1;
        while (!bus.error && elapsed < 40) begin
            applyStimulus(0, 0, 0, 16'h0);
            elapsed++;
        end
        checkOutput("timeout_cycles", 64'(elapsed), 64'(TIMEOUT));
        checkOutput("timeout_no_load", 64'(load_count), 64'd0);
        checkOutput("timeout_coeff_kept", bus.coeff_out, 64'h0004_0003_0002_0001);

        // Restart mid-sequence with a word in the restart cycle
        load_count = 0;
        applyStimulus(0, 1, 0, 16'h0);
        applyStimulus(0, 0, 1, 16'h0101);
        applyStimulus(0, 0, 1, 16'h0202);
        applyStimulus(0, 0, 1, 16'h0303);
        applyStimulus(0, 1, 1, 16'h9999);
        applyStimulus(0, 0, 1, 16'hAAAA);
        applyStimulus(0, 0, 1, 16'hBBBB);
        applyStimulus(0, 0, 1, 16'hCCCC);
        applyStimulus(0, 0, 1, 16'hDDDD);
`ifdef FIR_COEFF_CHECKSUM_EN
        applyStimulus(0, 0, 1, 16'(16'hAAAA + 16'hBBBB + 16'hCCCC + 16'hDDDD));
`endif
        checkOutput("restart_coeff", bus.coeff_out, 64'hDDDD_CCCC_BBBB_AAAA);
        checkOutput("restart_load_once", 64'(load_count), 64'd1);

        // Word in IDLE without start is ignored
        held = bus.coeff_out;
        applyStimulus(0, 0, 1, 16'h1234);
        checkOutput("idle_busy", 64'(bus.busy), 64'd0);
        checkOutput("idle_coeff", bus.coeff_out, held);

        // Reset mid-sequence, then a full load
        applyStimulus(0, 1, 0, 16'h0);
        applyStimulus(0, 0, 1, 16'h5555);
        applyStimulus(0, 0, 1, 16'h6666);
        applyStimulus(1, 0, 0, 16'h0);
        checkOutput("rst_coeff", bus.coeff_out, 64'h0);
        checkOutput("rst_busy", 64'(bus.busy), 64'd0);
        sendWords(16'h1357, 16'h2468, 16'h8000, 16'h7FFF);
        checkOutput("post_rst_coeff", bus.coeff_out, 64'h7FFF_8000_2468_1357);

`ifdef FIR_COEFF_CHECKSUM_EN
        // Checksum with wraparound: match then mismatch
        load_count = 0;
        applyStimulus(0, 1, 0, 16'h0);
        applyStimulus(0, 0, 1, 16'hFFFF);
        applyStimulus(0, 0, 1, 16'h0002);
        applyStimulus(0, 0, 1, 16'h0000);
        applyStimulus(0, 0, 1, 16'h0001);
        applyStimulus(0, 0, 1, 16'h0002);
        checkOutput("csum_coeff", bus.coeff_out, 64'h0001_0000_0002_FFFF);
        checkOutput("csum_load", 64'(load_count), 64'd1);
        load_count = 0;
        applyStimulus(0, 1, 0, 16'h0);
        applyStimulus(0, 0, 1, 16'hFFFF);
        applyStimulus(0, 0, 1, 16'h0002);
        applyStimulus(0, 0, 1, 16'h0000);
        applyStimulus(0, 0, 1, 16'h0001);
        applyStimulus(0, 0, 1, 16'h0003);
        checkOutput("csum_bad_error", 64'(bus.error), 64'd1);
        checkOutput("csum_bad_no_load", 64'(load_count), 64'd0);
        checkOutput("csum_bad_coeff", bus.coeff_out, 64'h0001_0000_0002_FFFF);
`endif

        // Randomized traffic at mixed word densities
        for (int s = 0; s < 60; s++) begin
            case ($urandom_range(0, 2))
                0: vp = 95;
                1: vp = 50;
                default: vp = 5;
            endcase
            applyStimulus(0, 1, 0, 16'h0);
            for (int c = 0; c < 30; c++) begin
                r  = int'($urandom_range(0, 999));
                rr = (r < 3);
                st = (r >= 3 && r < 15);
                v  = ($urandom_range(0, 99) < vp);
                d  = 16'($urandom);
`ifdef FIR_COEFF_CHECKSUM_EN
                if (m_collecting && m_words.size() == NUM_TAPS && $urandom_range(0, 1) == 1) d = wordSum();
`endif
                applyStimulus(rr, st, v, d);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", num_checks, num_fails);
        $finish;
    end
endmodule
